alu_serial_ctrl: RTL
====================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  operation request; sampled only in IDLE.
REQ-005 The block SHALL have port op  input  3  operation select: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
REQ-006 The block SHALL have ports a, b  input  WIDTH  operands; b is the subtrahend for SUB/SLT.
REQ-007 The block SHALL have port busy  output  1  high from the cycle after accept until done is high (inclusive).
REQ-008 The block SHALL have port done  output  1  one-cycle pulse; result and flags valid.
REQ-009 The block SHALL have port result  output  WIDTH  operation result, held until the next accept.
REQ-010 The block SHALL have ports carryout, overflow, zero  output  1 each  status flags, held with result.

Function
REQ-011 The block SHALL compute one result bit per cycle, LSB first, through a single shared 1-bit ALU slice implementing the eight REQ-005 functions; no WIDTH-wide adder SHALL exist.
REQ-012 The FSM SHALL have states IDLE, RUN, SLTFIX, DONE; reset state IDLE.
REQ-013 IDLE->RUN on start=1; a, b, op SHALL be latched on that edge (accept edge); bit counter cleared to 0.
REQ-014 RUN SHALL process bit index = counter each cycle and increment it; after bit WIDTH-1, go to SLTFIX if op=011, else DONE.
REQ-015 SLTFIX SHALL last one cycle and set result = {WIDTH-1 zeros, msb_of_difference XOR overflow}; then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 Latency SHALL be exactly WIDTH+1 cycles accept-edge to done-high edge, WIDTH+2 for SLT.
REQ-018 Carry register SHALL initialize to 1 for SUB/SLT (b inverted into the slice) and 0 for all other ops at the accept edge; it updates each RUN cycle with the slice carry-out.
REQ-019 carryout SHALL equal the carry out of bit WIDTH-1; overflow SHALL equal carry-in XOR carry-out of bit WIDTH-1; both SHALL be 0 for logical ops (010, 100-111).
REQ-020 zero SHALL be 1 iff the final result (post-SLTFIX) is all zeros; computed serially by OR-accumulation of result bits.
REQ-021 start SHALL be ignored in RUN, SLTFIX, DONE; no request queued; operands may change freely after accept.
REQ-022 result and flags SHALL be stable from done high until the next accept edge; result bits may update during RUN.
REQ-023 Back-to-back: start high during the DONE cycle SHALL be ignored; earliest next accept is the cycle after done.

Reset
REQ-024 reset_n low SHALL immediately (without clock) force state IDLE, counter 0, carry 0, busy 0, done 0, result 0, carryout 0, overflow 0, zero 0.
REQ-025 Reset asserted mid-operation SHALL abandon it; no done pulse SHALL follow reset deassertion.
REQ-026 After reset deassertion, the first rising edge with start=1 SHALL be a valid accept.

Verification
REQ-027 ADD a=0x0000_0001, b=0xFFFF_FFFF (WIDTH=32) -> done at accept+33, result=0, carryout=1, overflow=0, zero=1.
REQ-028 SUB a=0x8000_0000, b=0x0000_0001 -> result=0x7FFF_FFFF, carryout=1, overflow=1, zero=0.
REQ-029 SLT a=0xFFFF_FFFE (-2), b=0x0000_0003 -> done at accept+34, result=0x0000_0001; swap operands -> result=0, zero=1.
REQ-030 NOR a=0xF0F0_F0F0, b=0x0F0F_0F00 -> result=0x0000_000F, carryout=0, overflow=0, zero=0.
REQ-031 Accept ADD, hold start high and change a/b throughout, assert reset_n low at RUN bit 10 for 2 cycles -> all outputs 0 immediately, no done pulse; next start accepted normally.
REQ-032 Every op with random operands, back-to-back starts -> results match reference model, one done per accept, start during busy/DONE ignored.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU controller.
// One result bit is produced per clock, LSB first, through a single shared
// 1-bit ALU slice. Carry, overflow and zero are accumulated serially, and an
// optional fix-up cycle turns the SUB difference into a set-less-than result.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    // Counter only has to address bits 0..WIDTH-1.
    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SLTFIX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              or_acc_q, or_acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carryout_q, carryout_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_bit;
    logic              a_bit;
    logic              b_bit;
    logic              b_inv;
    logic              b_eff;
    logic              is_arith;
    logic              sum_bit;
    logic              add_cout;
    logic              slice_bit;
    logic              slice_cout;
    logic              slt_bit;

    // busy is still high during the done cycle, so a start held across the
    // end of an operation is ignored there and is only taken one cycle later.
    assign accept   = (state_q == S_IDLE) && start && !busy_q;
    assign last_bit = (cnt_q == LAST_BIT);

    // Set-less-than: sign of the difference corrected by signed overflow.
    assign slt_bit  = result_q[WIDTH-1] ^ overflow_q;

    // Shared 1-bit ALU slice operating on the bit selected by the counter.
    always_comb begin
        a_bit      = a_q[cnt_q];
        b_bit      = b_q[cnt_q];
        b_inv      = (op_q == OP_SUB) || (op_q == OP_SLT);
        is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
        b_eff      = b_bit ^ b_inv;
        sum_bit    = a_bit ^ b_eff ^ carry_q;
        add_cout   = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
        slice_cout = is_arith ? add_cout : 1'b0;
        slice_bit  = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_SLT: slice_bit = sum_bit;
            OP_XOR:                 slice_bit = a_bit ^ b_bit;
            OP_AND:                 slice_bit = a_bit & b_bit;
            OP_NAND:                slice_bit = ~(a_bit & b_bit);
            OP_NOR:                 slice_bit = ~(a_bit | b_bit);
            OP_OR:                  slice_bit = a_bit | b_bit;
            default:                slice_bit = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_d = (op_q == OP_SLT) ? S_SLTFIX : S_DONE;
                end
            end
            S_SLTFIX: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered: busy rises with the accept edge and covers
    // the done pulse, which follows the DONE state by one register stage.
    always_comb begin
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
        done_d = (state_q == S_DONE);
    end

    // Operand latch, bit counter, carry chain and flag accumulation.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        or_acc_d   = or_acc_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    cnt_d    = '0;
                    // The +1 of two's-complement subtraction enters as carry-in.
                    carry_d  = (op == OP_SUB) || (op == OP_SLT);
                    or_acc_d = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d    = last_bit ? '0 : cnt_q + CW'(1);
                carry_d  = slice_cout;
                or_acc_d = or_acc_q | slice_bit;
                if (last_bit) begin
                    carryout_d = slice_cout;
                    overflow_d = is_arith ? (carry_q ^ add_cout) : 1'b0;
                    zero_d     = ~(or_acc_q | slice_bit);
                end
            end
            S_SLTFIX: begin
                zero_d = ~slt_bit;
            end
            default: begin
            end
        endcase
    end

    // Per-bit result update: the addressed bit takes the slice output during
    // RUN; SLTFIX collapses the word to the single comparison bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result_bit
            if (gi == 0) begin : g_lsb
                assign result_d[gi] =
                    ((state_q == S_RUN) && (cnt_q == CW'(gi))) ? slice_bit :
                    (state_q == S_SLTFIX)                      ? slt_bit   :
                                                                 result_q[gi];
            end else begin : g_upper
                assign result_d[gi] =
                    ((state_q == S_RUN) && (cnt_q == CW'(gi))) ? slice_bit :
                    (state_q == S_SLTFIX)                      ? 1'b0      :
                                                                 result_q[gi];
            end
        end
    endgenerate

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 3'b000;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            or_acc_q   <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            or_acc_q   <= or_acc_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
